// File: rtl/ov7670_dvp_tx.sv
// OV7670-style DVP transmitter: VSYNC/HREF/RGB444 byte stream from an internal test pattern.
// Define DVP_TX_EXT_PIX_EN to add the pix_req/pix_in external pixel source for pattern 3.
module ov7670_dvp_tx #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
`ifdef DVP_TX_EXT_PIX_EN
  output logic        pix_req,
  input  logic [11:0] pix_in,
`endif
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_d,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  // state  | meaning
  // IDLE   | stopped, outputs quiet
  // VSYNC  | VSYNC_LINES lines with dvp_vsync high
  // VBACK  | V_BACK blank lines before the picture
  // ACTIVE | V_ACTIVE lines, HREF high for 2*H_ACTIVE bytes each
  // VFRONT | V_FRONT blank lines; frame_done in its last cycle
  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  localparam int L         = 2 * H_ACTIVE + H_BLANK;
  localparam int HC_W      = ($clog2(L) < 9) ? 9 : $clog2(L);
  localparam int N_LINES   = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int LC_W      = ($clog2(N_LINES) < 5) ? 5 : $clog2(N_LINES);
  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(L - 1);
  localparam logic [HC_W-1:0] HREF_END = HC_W'(2 * H_ACTIVE);
  localparam logic [HC_W-2:0] BAR_W    = (HC_W - 1)'(H_ACTIVE / 8);

  state_t            state, state_n;
  logic [HC_W-1:0]   hc, hc_n;
  logic [LC_W-1:0]   lc, lc_n, lc_last;
  logic [1:0]        pat;
  logic [HC_W-2:0]   x_n;
  logic [2:0]        bar;
  logic [11:0]       px;
  logic              href_n;
  logic              done_n;

  // The registers below describe the cycle currently on the pins; outputs are
  // computed from the next position so they are registered without a lag.
  always_comb begin
    state_n = state;
    hc_n    = hc;
    lc_n    = lc;
    case (state)
      S_VSYNC:  lc_last = LC_W'(VSYNC_LINES - 1);
      S_VBACK:  lc_last = LC_W'(V_BACK - 1);
      S_ACTIVE: lc_last = LC_W'(V_ACTIVE - 1);
      S_VFRONT: lc_last = LC_W'(V_FRONT - 1);
      default:  lc_last = '0;
    endcase
    if (state == S_IDLE) begin
      if (en) state_n = S_VSYNC;
    end else if (hc != HC_LAST) begin
      hc_n = hc + 1'b1;
    end else begin
      hc_n = '0;
      if (lc != lc_last) begin
        lc_n = lc + 1'b1;
      end else begin
        lc_n = '0;
        case (state)
          S_VSYNC:  state_n = S_VBACK;
          S_VBACK:  state_n = S_ACTIVE;
          S_ACTIVE: state_n = S_VFRONT;
          S_VFRONT: state_n = en ? S_VSYNC : S_IDLE;
          default:  state_n = S_IDLE;
        endcase
      end
    end
  end

`ifdef DVP_TX_EXT_PIX_EN
  logic       req_n;
  logic       req_d;
  logic [7:0] ext_gb;
`endif

  always_comb begin
    x_n = hc_n[HC_W-1:1];
    bar = 3'(x_n / BAR_W);
    case (pat)
      2'd0:    px = {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}};
      2'd1:    px = {3{x_n[7:4]}};
      2'd2:    px = (x_n[4] ^ lc_n[4]) ? 12'hFFF : 12'h000;
`ifdef DVP_TX_EXT_PIX_EN
      // byte0 takes R straight from the source; G,B were captured the cycle before
      default: px = hc_n[0] ? {4'h0, ext_gb} : pix_in;
`else
      default: px = 12'hFFF;
`endif
    endcase
    href_n = (state_n == S_ACTIVE) && (hc_n < HREF_END);
    done_n = (state_n == S_VFRONT) && (lc_n == LC_W'(V_FRONT - 1)) && (hc_n == HC_LAST);
`ifdef DVP_TX_EXT_PIX_EN
    // Request two cycles ahead of each byte0; x=0 is requested from the previous line's tail.
    req_n = (pat == 2'd3) &&
            (((state_n == S_ACTIVE) && !hc_n[0] && (hc_n <= HC_W'(2 * H_ACTIVE - 4))) ||
             ((hc_n == HC_W'(L - 2)) &&
              (((state_n == S_VBACK) && (lc_n == LC_W'(V_BACK - 1))) ||
               ((state_n == S_ACTIVE) && (lc_n != LC_W'(V_ACTIVE - 1))))));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hc         <= '0;
      lc         <= '0;
      pat        <= 2'd0;
      dvp_vsync  <= 1'b0;
      dvp_href   <= 1'b0;
      dvp_d      <= 8'h00;
      frame_done <= 1'b0;
      frame_cnt  <= 8'h00;
      busy       <= 1'b0;
    end else begin
      state <= state_n;
      hc    <= hc_n;
      lc    <= lc_n;
      if (state_n == S_VSYNC && state != S_VSYNC) pat <= pattern_sel;
      dvp_vsync  <= (state_n == S_VSYNC);
      dvp_href   <= href_n;
      dvp_d      <= href_n ? (hc_n[0] ? px[7:0] : {4'h0, px[11:8]}) : 8'h00;
      frame_done <= done_n;
      if (done_n) frame_cnt <= frame_cnt + 1'b1;
      busy       <= (state_n != S_IDLE);
    end
  end

`ifdef DVP_TX_EXT_PIX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_req <= 1'b0;
      req_d   <= 1'b0;
      ext_gb  <= 8'h00;
    end else begin
      pix_req <= req_n;
      req_d   <= pix_req;
      if (req_d) ext_gb <= pix_in[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_dvp_tx.sv
// Self-checking bench for ov7670_dvp_tx with a reduced vertical geometry; the
// reference model derives every output from the cycle offset within the frame.
module tb_ov7670_dvp_tx;
  localparam int HA = 320, VA = 17, HB = 16, VS = 2, VB = 1, VF = 1;
  localparam int L  = 2 * HA + HB;
  localparam int FR = (VS + VB + VA + VF) * L;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        dvp_vsync, dvp_href, frame_done, busy;
  logic [7:0]  dvp_d, frame_cnt;
`ifdef DVP_TX_EXT_PIX_EN
  logic        pix_req;
  logic [11:0] pix_in = 12'h000;
  logic [11:0] ext_ctr = 12'hABC;
  logic [11:0] cur_ext = 12'h000;
  logic [11:0] ext_q[$];
`endif

  always #5 clk = ~clk;

  ov7670_dvp_tx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
                  .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
`ifdef DVP_TX_EXT_PIX_EN
    .pix_req(pix_req), .pix_in(pix_in),
`endif
    .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_d(dvp_d),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pix_of(input logic [1:0] p, input int x, input int y);
    case (p)
      2'd0: case (x / (HA / 8))
              0: return 12'hFFF;  1: return 12'hFF0;  2: return 12'h0FF;  3: return 12'h0F0;
              4: return 12'hF0F;  5: return 12'hF00;  6: return 12'h00F;  default: return 12'h000;
            endcase
      2'd1: begin
        logic [3:0] n;
        n = 4'((x / 16) % 16);
        return {n, n, n};
      end
      2'd2: return (((x / 16) ^ (y / 16)) % 2 == 1) ? 12'hFFF : 12'h000;
      default: return 12'hFFF;
    endcase
  endfunction

  // Model: t = cycle offset within the running frame, -1 when idle.
  int         t = -1;
  int         mcnt = 0;
  logic [1:0] mpat = 2'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= -1;
      mcnt <= 0;
    end else if (t < 0 || t == FR - 1) begin
      if (en) begin
        t <= 0;
        mpat <= pattern_sel;
      end else begin
        t <= -1;
      end
    end else begin
      t <= t + 1;
      if (t + 1 == FR - 1) mcnt <= (mcnt + 1) % 256;
    end
  end

  function automatic bit active_at(input int tt);
    int line, col, ay;
    if (tt < 0) return 1'b0;
    line = tt / L;
    col  = tt % L;
    ay   = line - VS - VB;
    return (ay >= 0) && (ay < VA) && (col < 2 * HA);
  endfunction

  int hlen = 0, hpulses = 0, fd_total = 0;

  always @(negedge clk) begin
    int line, col, ay, x;
    bit act, odd;
    logic [11:0] px;
    logic [7:0]  ed;
    line = (t >= 0) ? t / L : 0;
    col  = (t >= 0) ? t % L : 0;
    ay   = line - VS - VB;
    x    = col / 2;
    odd  = (col % 2) == 1;
    act  = active_at(t);
    px   = pix_of(mpat, x, ay);
`ifdef DVP_TX_EXT_PIX_EN
    if (!rst_n) ext_q.delete();
    if (t == 0 && mpat == 2'd3) ext_ctr = 12'hABC;
    if (act && mpat == 2'd3) begin
      if (!odd) begin
        check("ext_req_before_pixel", int'(ext_q.size() > 0), 1);
        if (ext_q.size() > 0) cur_ext = ext_q.pop_front();
      end
      px = cur_ext;
    end
`endif
    ed = act ? (odd ? px[7:0] : {4'h0, px[11:8]}) : 8'h00;

    check("vsync", dvp_vsync, int'(t >= 0 && line < VS));
    check("href", dvp_href, int'(act));
    check("data", dvp_d, ed);
    check("frame_done", frame_done, int'(t == FR - 1));
    check("frame_cnt", frame_cnt, mcnt);
    check("busy", busy, int'(t >= 0));
`ifdef DVP_TX_EXT_PIX_EN
    check("pix_req", pix_req, int'(t >= 0 && mpat == 2'd3 && active_at(t + 2) && ((t + 2) % L) % 2 == 0));
    if (act && mpat == 2'd3 && ay == 0 && x == 0)
      check("ext_first_pixel", dvp_d, odd ? 8'hBC : 8'h0A);
    if (pix_req) begin
      pix_in = ext_ctr;
      ext_q.push_back(ext_ctr);
      ext_ctr = ext_ctr + 12'd1;
    end
`else
    if (act && mpat == 2'd3 && ay == 0 && x == 0)
      check("solid_fff", dvp_d, odd ? 8'hFF : 8'h0F);
`endif

    // hand-derived literals that pin the pattern model
    if (act && mpat == 2'd0 && ay == 0 && x == 0)   check("bar_white", dvp_d, odd ? 8'hFF : 8'h0F);
    if (act && mpat == 2'd0 && ay == 0 && x == 40)  check("bar_yellow", dvp_d, odd ? 8'hF0 : 8'h0F);
    if (act && mpat == 2'd0 && ay == 0 && x == 280) check("bar_black", dvp_d, 8'h00);
    if (act && mpat == 2'd2 && ay == 0 && x == 16)  check("checker_y0", dvp_d, odd ? 8'hFF : 8'h0F);
    if (act && mpat == 2'd2 && ay == 16 && x == 16) check("checker_y16", dvp_d, 8'h00);
    if (act && mpat == 2'd1 && ay == 0 && x == 255) check("ramp_255", dvp_d, odd ? 8'hFF : 8'h0F);
    if (act && mpat == 2'd1 && ay == 0 && x == 256) check("ramp_256", dvp_d, 8'h00);

    if (!rst_n) begin
      hlen = 0;
      hpulses = 0;
    end else begin
      if (dvp_href) hlen++;
      else if (hlen > 0) begin
        check("href_len", hlen, 2 * HA);
        hpulses++;
        hlen = 0;
      end
      if (frame_done) begin
        check("href_per_frame", hpulses, VA);
        hpulses = 0;
        fd_total++;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < FR + 50);
    check(name, busy, 0);
  endtask

  initial begin
    int n, vs, fd0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vsync", dvp_vsync, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single-cycle en pulse: exactly one colour-bar frame
    fd0 = fd_total;
    pattern_sel = 2'd0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    pattern_sel = 2'($urandom);
    wait_idle("frame1_idle");
    check("frame1_done_count", fd_total - fd0, 1);
    check("frame1_cnt", frame_cnt, 1);

    // back-to-back ramp then checkerboard, pattern_sel scrambled mid-frame
    pattern_sel = 2'd1;
    en = 1'b1;
    @(negedge clk);
    n = 0;
    while (!frame_done && n < FR + 10) begin
      pattern_sel = 2'($urandom);
      @(negedge clk);
      n++;
    end
    check("frame2_end", frame_done, 1);
    pattern_sel = 2'd2;
    @(negedge clk);
    n = 0;
    while (!frame_done && n < FR + 10) begin
      pattern_sel = 2'($urandom);
      @(negedge clk);
      n++;
    end
    check("frame3_end", frame_done, 1);
    en = 1'b0;
    wait_idle("frame3_idle");

    // pattern 3 frame with en jittering briefly after start
    pattern_sel = 2'd3;
    en = 1'b1;
    repeat ($urandom_range(1, 20)) begin
      @(negedge clk);
      en = 1'($urandom);
      pattern_sel = 2'($urandom);
    end
    en = 1'b0;
    wait_idle("frame4_idle");

    // reset in the middle of an active line
    pattern_sel = 2'($urandom);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n = 0;
    while (!dvp_href && n < FR) begin
      @(negedge clk);
      n++;
    end
    check("href_seen", dvp_href, 1);
    repeat ($urandom_range(0, 300)) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_now_vsync", dvp_vsync, 0);
    check("rst_now_href", dvp_href, 0);
    check("rst_now_d", dvp_d, 0);
    check("rst_now_done", frame_done, 0);
    check("rst_now_cnt", frame_cnt, 0);
    check("rst_now_busy", busy, 0);
`ifdef DVP_TX_EXT_PIX_EN
    check("rst_now_req", pix_req, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    n = 0;
    while (!dvp_vsync && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("vsync_latency", n, 1);
    check("busy_latency", busy, 1);
    en = 1'b0;
    vs = 0;
    while (dvp_vsync && vs < VS * L + 10) begin
      vs++;
      @(negedge clk);
    end
    check("vsync_len", vs, VS * L);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
